// File: rtl/phoenix_pkg.sv
// Shared RV32I encodings, ALU/immediate enums and the pure-combinational helpers
// that the phoenix_core datapath is built from.
package phoenix_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  function automatic word_t imm_gen(input word_t instr, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

  // alt selects SUB/SRA; the caller masks it for immediate forms that have no SUB
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic word_t alu_exec(input alu_op_e op, input word_t a, input word_t b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input word_t a, input word_t b);
    case (funct3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phoenix_if.sv
// Register-file access bundle between the core datapath (master) and the
// register file (slave): two combinational read ports and one write port.
interface phoenix_if;
  import phoenix_pkg::*;

  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  word_t     rs1_data;
  word_t     rs2_data;
  reg_addr_t rd_addr;
  word_t     rd_data;
  logic      rd_en;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, rd_en,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, rd_en,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/phoenix_register_file.sv
// 32 x 32-bit register file; x0 is hardwired to zero, reads are combinational
// so a same-cycle write is only visible after the edge.
module phoenix_register_file
  import phoenix_pkg::*;
(
  input logic      CLK,
  input logic      reset,
  phoenix_if.slave rf
);

  word_t Registers [0:31];

  assign rf.rs1_data = (rf.rs1_addr == '0) ? '0 : Registers[rf.rs1_addr];
  assign rf.rs2_data = (rf.rs2_addr == '0) ? '0 : Registers[rf.rs2_addr];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (rf.rd_en && rf.rd_addr != '0) begin
      Registers[rf.rd_addr] <= rf.rd_data;
    end
  end

endmodule

// File: rtl/phoenix_core.sv
// Single-cycle RV32I core: every CLK edge retires one instruction. The memories
// sit in fixed named scopes so they can be preloaded and inspected by hierarchy.
module phoenix_core
  import phoenix_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10
) (
  input logic CLK,
  input logic reset
);

  localparam int AW = ADDRESS_WIDTH;

  logic [AW-1:0] pc, pc_plus4, next_pc;
  logic          halted, halt_now, stall;
  word_t         instruction, imm, op_a, op_b, alu_result;
  word_t         load_raw, load_data, rd_value;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  imm_fmt_e      imm_fmt;
  alu_op_e       alu_op;
  logic          rd_write, store_req;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] byte_addr [4];
  logic [3:0]    store_mask;

  phoenix_if rf_bus ();

  phoenix_register_file register_file (
    .CLK   (CLK),
    .reset (reset),
    .rf    (rf_bus)
  );

  if (1) begin : fetch_unit
    if (1) begin : instruction_memory
      word_t Memory [0:(2**(AW-2))-1];
      assign instruction = Memory[pc[AW-1:2]];
    end
  end

  assign opcode          = instruction[6:0];
  assign funct3          = instruction[14:12];
  assign rf_bus.rs1_addr = instruction[19:15];
  assign rf_bus.rs2_addr = instruction[24:20];
  assign rf_bus.rd_addr  = instruction[11:7];
  assign pc_plus4        = pc + AW'(4);

  always_comb begin
    case (opcode)
      STORE:       imm_fmt = IMM_S;
      BRANCH:      imm_fmt = IMM_B;
      LUI, AUIPC:  imm_fmt = IMM_U;
      JAL:         imm_fmt = IMM_J;
      default:     imm_fmt = IMM_I;
    endcase
  end

  assign imm = imm_gen(instruction, imm_fmt);

  // Operand selection; loads, stores and JALR reuse the adder for rs1 + imm.
  always_comb begin
    alu_op = ALU_ADD;
    op_a   = rf_bus.rs1_data;
    op_b   = imm;
    case (opcode)
      LUI:    op_a = '0;
      AUIPC:  op_a = word_t'(pc);
      OP_IMM: alu_op = alu_decode(funct3, instruction[30] && funct3 == F3_SR);
      OP: begin
        op_b   = rf_bus.rs2_data;
        alu_op = alu_decode(funct3, instruction[30]);
      end
      default: ;
    endcase
  end

  assign alu_result = alu_exec(alu_op, op_a, op_b);
  assign mem_addr   = alu_result[AW-1:0];

  always_comb begin
    next_pc   = pc_plus4;
    rd_value  = alu_result;
    rd_write  = 1'b0;
    store_req = 1'b0;
    halt_now  = 1'b0;
    case (opcode)
      LUI, AUIPC, OP_IMM, OP: rd_write = 1'b1;
      JAL: begin
        rd_write = 1'b1;
        rd_value = word_t'(pc_plus4);
        next_pc  = pc + imm[AW-1:0];
      end
      JALR: begin
        rd_write = 1'b1;
        rd_value = word_t'(pc_plus4);
        next_pc  = alu_result[AW-1:0];
      end
      BRANCH: begin
        if (branch_taken(funct3, rf_bus.rs1_data, rf_bus.rs2_data))
          next_pc = pc + imm[AW-1:0];
      end
      LOAD: begin
        rd_write = 1'b1;
        rd_value = load_data;
      end
      STORE:    store_req = 1'b1;
      MISC_MEM: ;
      default:  halt_now = 1'b1;
    endcase
  end

  assign stall          = halted | halt_now;
  assign rf_bus.rd_en   = rd_write & ~stall;
  assign rf_bus.rd_data = rd_value;

  always_comb begin
    for (int i = 0; i < 4; i++) byte_addr[i] = mem_addr + AW'(i);
  end

  always_comb begin
    case (funct3)
      F3_SB:   store_mask = 4'b0001;
      F3_SH:   store_mask = 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{load_raw[7]}}, load_raw[7:0]};
      F3_LH:   load_data = {{16{load_raw[15]}}, load_raw[15:0]};
      F3_LBU:  load_data = {24'b0, load_raw[7:0]};
      F3_LHU:  load_data = {16'b0, load_raw[15:0]};
      default: load_data = load_raw;
    endcase
  end

  // Bytewise access lets misaligned and top-of-memory accesses wrap naturally.
  if (1) begin : load_store_unit
    if (1) begin : data_memory
      logic [7:0] Memory [0:(2**AW)-1];

      assign load_raw = {Memory[byte_addr[3]], Memory[byte_addr[2]],
                         Memory[byte_addr[1]], Memory[byte_addr[0]]};

      always_ff @(posedge CLK) begin
        if (reset && store_req && !stall) begin
          for (int i = 0; i < 4; i++) begin
            if (store_mask[i]) Memory[byte_addr[i]] <= rf_bus.rs2_data[8*i +: 8];
          end
        end
      end
    end
  end

  // Targets are forced to word alignment, which also covers the JALR bit-0 clear.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!stall) begin
      pc <= next_pc & ~AW'(3);
    end else begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phoenix_core.sv
// Directed-program bench for phoenix_core: loads programs by hierarchy and
// compares registers, PC and data memory against hand-computed values.
module tb_phoenix_core;

  localparam int AW        = 10;
  localparam int OPC_LOAD  = 3;
  localparam int OPC_OPIMM = 19;
  localparam int OPC_AUIPC = 23;
  localparam int OPC_LUI   = 55;
  localparam int OPC_JALR  = 103;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;
  logic [31:0] prog [$];
  int   vals [8] = '{7, -3, 120, 45, 119, 0, -100, 88};

  phoenix_core #(.ADDRESS_WIDTH(AW)) dut (
    .CLK   (CLK),
    .reset (reset)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic loadProgram();
    for (int i = 0; i < 2**(AW-2); i++) dut.fetch_unit.instruction_memory.Memory[i] = '0;
    foreach (prog[i]) dut.fetch_unit.instruction_memory.Memory[i] = prog[i];
  endtask

  function automatic logic [31:0] reg_val(input int idx);
    return dut.register_file.Registers[idx];
  endfunction

  function automatic logic [31:0] dmem_word(input int a);
    return {dut.load_store_unit.data_memory.Memory[a+3], dut.load_store_unit.data_memory.Memory[a+2],
            dut.load_store_unit.data_memory.Memory[a+1], dut.load_store_unit.data_memory.Memory[a]};
  endfunction

  function automatic logic [31:0] pc_val();
    return 32'(dut.pc);
  endfunction

  function automatic logic [31:0] encI(input int opc, input int f3, input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] encS(input int f3, input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encU(input int opc, input int rd, input int imm20);
    return {imm20[19:0], rd[4:0], opc[6:0]};
  endfunction

  function automatic logic [31:0] encJ(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] encR(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  initial begin
    #1 reset = 1'b0;

    // Walk-through program: ALU, loads/stores, branches, jumps, x0, halt
    prog = {};
    prog.push_back(encI(OPC_OPIMM, 0, 1, 0, 5));        // 00 addi x1,x0,5
    prog.push_back(encI(OPC_OPIMM, 0, 2, 1, -7));       // 04 addi x2,x1,-7
    prog.push_back(encS(2, 2, 0, 12));                  // 08 sw x2,12(x0)
    prog.push_back(encI(OPC_LOAD, 0, 3, 0, 12));        // 0C lb x3,12(x0)
    prog.push_back(encI(OPC_LOAD, 4, 4, 0, 12));        // 10 lbu x4,12(x0)
    prog.push_back(encB(0, 1, 2, 8));                   // 14 beq x1,x2,+8
    prog.push_back(encB(0, 0, 0, 8));                   // 18 beq x0,x0,+8
    prog.push_back(EBREAK_W);                           // 1C
    prog.push_back(encJ(1, 16));                        // 20 jal x1,+16
    prog.push_back(encI(OPC_OPIMM, 0, 0, 0, 1));        // 24 addi x0,x0,1
    prog.push_back(encR(32, 0, 5, 0, 1));               // 28 sub x5,x0,x1
    prog.push_back(encJ(0, 20));                        // 2C jal x0,+20
    prog.push_back(encI(OPC_JALR, 0, 0, 1, 0));         // 30 jalr x0,0(x1)
    prog.push_back(EBREAK_W);                           // 34
    prog.push_back(EBREAK_W);                           // 38
    prog.push_back(EBREAK_W);                           // 3C
    prog.push_back(encI(OPC_OPIMM, 5, 6, 5, 32'h402));  // 40 srai x6,x5,2
    prog.push_back(encR(0, 3, 7, 0, 5));                // 44 sltu x7,x0,x5
    prog.push_back(encR(0, 2, 8, 5, 0));                // 48 slt x8,x5,x0
    prog.push_back(encI(OPC_OPIMM, 5, 9, 5, 28));       // 4C srli x9,x5,28
    prog.push_back(encU(OPC_LUI, 10, 32'h12345));       // 50 lui x10,0x12345
    prog.push_back(encU(OPC_AUIPC, 11, 1));             // 54 auipc x11,1
    prog.push_back(encS(1, 10, 0, 21));                 // 58 sh x10,21(x0)
    prog.push_back(encI(OPC_LOAD, 5, 12, 0, 21));       // 5C lhu x12,21(x0)
    prog.push_back(encI(OPC_LOAD, 1, 13, 0, 13));       // 60 lh x13,13(x0)
    prog.push_back(EBREAK_W);                           // 64
    loadProgram();

    applyStimulus(2);
    checkOutput("reset_pc", pc_val(), 32'h0);
    checkOutput("reset_x1", reg_val(1), 32'h0);
    checkOutput("reset_x31", reg_val(31), 32'h0);

    @(negedge CLK);
    reset = 1'b1;
    applyStimulus(2);
    checkOutput("addi_x1", reg_val(1), 32'h0000_0005);
    checkOutput("addi_x2", reg_val(2), 32'hFFFF_FFFE);
    checkOutput("pc_after_addi", pc_val(), 32'h8);

    applyStimulus(3);
    checkOutput("sw_word12", dmem_word(12), 32'hFFFF_FFFE);
    checkOutput("lb_x3", reg_val(3), 32'hFFFF_FFFE);
    checkOutput("lbu_x4", reg_val(4), 32'h0000_00FE);
    checkOutput("pc_after_loads", pc_val(), 32'h14);

    applyStimulus(1);
    checkOutput("beq_not_taken_pc", pc_val(), 32'h18);
    applyStimulus(1);
    checkOutput("beq_taken_pc", pc_val(), 32'h20);
    applyStimulus(1);
    checkOutput("jal_link_x1", reg_val(1), 32'h24);
    checkOutput("jal_pc", pc_val(), 32'h30);
    applyStimulus(1);
    checkOutput("jalr_pc", pc_val(), 32'h24);
    applyStimulus(1);
    checkOutput("x0_stays_zero", reg_val(0), 32'h0);
    checkOutput("pc_after_x0", pc_val(), 32'h28);
    applyStimulus(2);
    checkOutput("sub_x5", reg_val(5), 32'hFFFF_FFDC);
    checkOutput("jal_x0_pc", pc_val(), 32'h40);

    applyStimulus(12);
    checkOutput("srai_x6", reg_val(6), 32'hFFFF_FFF7);
    checkOutput("sltu_x7", reg_val(7), 32'h1);
    checkOutput("slt_x8", reg_val(8), 32'h1);
    checkOutput("srli_x9", reg_val(9), 32'hF);
    checkOutput("lui_x10", reg_val(10), 32'h1234_5000);
    checkOutput("auipc_x11", reg_val(11), 32'h0000_1054);
    checkOutput("lhu_misaligned_x12", reg_val(12), 32'h0000_5000);
    checkOutput("lh_misaligned_x13", reg_val(13), 32'hFFFF_FFFF);
    checkOutput("sh_keeps_word12", dmem_word(12), 32'hFFFF_FFFE);
    checkOutput("ebreak_holds_pc", pc_val(), 32'h64);
    checkOutput("halt_keeps_x1", reg_val(1), 32'h24);

    // Max-of-array: signed max over eight stored words
    reset = 1'b0;
    prog = {};
    prog.push_back(encI(OPC_OPIMM, 0, 5, 0, 256));
    foreach (vals[i]) begin
      prog.push_back(encI(OPC_OPIMM, 0, 6, 0, vals[i]));
      prog.push_back(encS(2, 6, 5, 4 * i));
    end
    prog.push_back(encI(OPC_OPIMM, 0, 7, 0, 8));        // 44 count
    prog.push_back(encI(OPC_OPIMM, 0, 8, 5, 0));        // 48 ptr
    prog.push_back(encI(OPC_LOAD, 2, 9, 8, 0));         // 4C max = a[0]
    prog.push_back(encI(OPC_LOAD, 2, 10, 8, 0));        // 50 loop: lw x10
    prog.push_back(encB(5, 9, 10, 8));                  // 54 bge x9,x10,+8
    prog.push_back(encI(OPC_OPIMM, 0, 9, 10, 0));       // 58 max = x10
    prog.push_back(encI(OPC_OPIMM, 0, 8, 8, 4));        // 5C ptr += 4
    prog.push_back(encI(OPC_OPIMM, 0, 7, 7, -1));       // 60 count--
    prog.push_back(encB(1, 7, 0, -20));                 // 64 bne x7,x0,loop
    prog.push_back(encS(2, 9, 5, 32));                  // 68 sw x9,32(x5)
    prog.push_back(EBREAK_W);                           // 6C
    loadProgram();
    applyStimulus(1);
    checkOutput("reset_clears_x5", reg_val(5), 32'h0);
    @(negedge CLK);
    reset = 1'b1;
    applyStimulus(800);
    checkOutput("max_stored", dmem_word(32'h120), 32'd120);
    checkOutput("array_word6", dmem_word(32'h118), 32'hFFFF_FF9C);
    checkOutput("array_word1", dmem_word(32'h104), 32'hFFFF_FFFD);
    checkOutput("max_count_x7", reg_val(7), 32'h0);
    checkOutput("max_halt_pc", pc_val(), 32'h6C);

    // Counter loop interrupted by an asynchronous reset
    reset = 1'b0;
    prog = {};
    prog.push_back(encI(OPC_OPIMM, 0, 1, 0, 0));        // 00 addi x1,x0,0
    prog.push_back(encI(OPC_OPIMM, 0, 1, 1, 1));        // 04 addi x1,x1,1
    prog.push_back(encS(2, 1, 0, 512));                 // 08 sw x1,0x200(x0)
    prog.push_back(encJ(0, -8));                        // 0C jal x0,-8
    loadProgram();
    applyStimulus(1);
    @(negedge CLK);
    reset = 1'b1;
    applyStimulus(8);
    checkOutput("loop_x1", reg_val(1), 32'h3);
    checkOutput("loop_pc", pc_val(), 32'h8);
    checkOutput("loop_mem", dmem_word(32'h200), 32'h2);

    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_pc", pc_val(), 32'h0);
    checkOutput("async_reset_x1", reg_val(1), 32'h0);
    checkOutput("async_reset_mem_kept", dmem_word(32'h200), 32'h2);
    applyStimulus(2);
    checkOutput("held_reset_mem", dmem_word(32'h200), 32'h2);
    checkOutput("held_reset_pc", pc_val(), 32'h0);

    @(negedge CLK);
    reset = 1'b1;
    applyStimulus(3);
    checkOutput("restart_x1", reg_val(1), 32'h1);
    checkOutput("restart_mem", dmem_word(32'h200), 32'h1);
    checkOutput("restart_pc", pc_val(), 32'hC);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/phoenix_core.md
# phoenix_core

Single-cycle RV32I processor core with private instruction and data memories, serving as the top-level CPU of the phoeniX platform. It fetches one 32-bit instruction per clock from an internal instruction memory preloaded by the bench. It executes the instruction, and on the same clock edge updates the PC, the register file and the data memory. The core has no bus or external memory port; it is observed through fixed hierarchical memory and register names.

## Interface
- ADDRESS_WIDTH, default 10: byte-address width of each memory; each memory spans 2^ADDRESS_WIDTH bytes.
- CLK  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 = in reset.
- No other ports.

## Operation
- Hierarchy names are fixed; the bench loads and dumps through them:
  - fetch_unit.instruction_memory.Memory: 32-bit words, depth 2^(ADDRESS_WIDTH-2), read combinationally at PC[ADDRESS_WIDTH-1:2].
  - load_store_unit.data_memory.Memory: 8-bit entries, depth 2^ADDRESS_WIDTH, little-endian.
  - register_file.Registers[0:31]: 32-bit registers.
- Supported instructions: full RV32I user ISA.
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LB, LH, LW, LBU, LHU; SB, SH, SW.
  - ALU immediate and register ops, including SLT/SLTU and the shifts.
- FENCE is a NOP: PC+4, no other effect.
- ECALL, EBREAK and any illegal opcode halt the core:
  - PC holds; no register or memory write.
  - Only reset leaves this state.
- Arithmetic is 32-bit and wraps; there are no overflow traps.
- Shifts use rs2[4:0] or shamt; SRA/SRAI sign-fill.
- JALR target = (rs1 + imm) & ~1.
- Branch and jump targets are PC-relative with sign-extended immediates.
- Loads sign- or zero-extend per funct3.
- Stores write only the addressed 1, 2 or 4 bytes.
- Data addresses are taken modulo 2^ADDRESS_WIDTH; a multi-byte access wraps at the top byte.
- Misaligned data accesses are performed bytewise, with no trap.
- PC wraps modulo 2^ADDRESS_WIDTH.
- Instruction fetch ignores PC[1:0]; any jump target with PC[1:0] ≠ 0 is truncated to word alignment.
- x0 always reads 0; writes to x0 are discarded.
- Register reads are combinational, so a write and a read of the same register in one cycle return the old value.

## Timing
- While reset = 0:
  - PC = 0.
  - All 32 registers = 0.
  - Halt flag cleared.
  - Memories are not cleared.
- Each CLK rising edge with reset = 1 retires exactly one instruction: CPI = 1, latency 1 cycle.
- Results are visible in register_file / data_memory immediately after the edge.
- Data memory reads are combinational; writes are synchronous on CLK.
- Reset asserted mid-execution:
  - PC and registers are forced to 0 asynchronously.
  - The in-flight store is discarded; memory contents written before the assertion are retained.
- First instruction executes on the first rising edge after reset deasserts.

## Structure
- Shared package phoenix_pkg holds:
  - opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM;
  - funct3 codes;
  - ALU-operation enum;
  - immediate-format enum (I/S/B/U/J).
- Instance names required by the hierarchy:
  - fetch_unit (contains instruction_memory);
  - load_store_unit (contains data_memory);
  - register_file.
- One natural sub-module: phoenix_register_file (2 read ports, 1 write port, async reset).
- Decode, immediate generation and the ALU stay in the top level or in package functions.

## Test plan
- Reset, then ADDI x1,x0,5; ADDI x2,x1,-7 → after 2 cycles x1=5, x2=0xFFFFFFFE, PC=8.
- SW x2,12(x0), then LB x3,12(x0), then LBU x4,12(x0):
  - data Memory[12..15] = FE FF FF FF;
  - x3 = 0xFFFFFFFE;
  - x4 = 0x000000FE.
- BEQ taken and not taken; JAL x1,+16 from PC 0x20; JALR x0,0(x1):
  - JAL: x1 = 0x24, PC = 0x30;
  - JALR: returns to 0x24.
- ADDI x0,x0,1 → x0 stays 0.
- Max-of-array program, 8 words preloaded via SW, max stored to a fixed address → after 8000 ns the stored word equals the true maximum; EBREAK then holds PC.
- Deassert reset (set to 0) mid-loop → PC and registers become 0 at once, earlier stores persist, execution restarts at 0 on release.
